// File: rtl/phy_pkg.sv
// Shared PHY link definitions (symbol defaults, lane geometry, TX FSM encoding),
// used by both phy_tx and phy_rx.
package phy_pkg;
  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] COM_BYTE_DEF  = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEF = 8'h7C;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  // A lane's on-wire byte: its data when valid, otherwise the idle symbol.
  function automatic logic [BYTE_W-1:0] lane_byte(input logic vld,
                                                  input logic [BYTE_W-1:0] data,
                                                  input logic [BYTE_W-1:0] idle);
    return vld ? data : idle;
  endfunction
endpackage

// File: rtl/phy_tx_serializer.sv
// MSB-first byte serializer: shifts one bit per clock and parallel-loads the
// next byte on the edge that retires bit 7.
import phy_pkg::*;

module phy_tx_serializer #(
  parameter logic [BYTE_W-1:0] RESET_BYTE = COM_BYTE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_load_byte,
  output logic              o_serial,
  output logic              o_byte_done
);
  logic [2:0]        r_bit_cnt;
  logic [BYTE_W-1:0] r_shreg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
      r_shreg   <= RESET_BYTE;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (r_bit_cnt == 3'd7) r_shreg <= i_load_byte;
      else                   r_shreg <= {r_shreg[BYTE_W-2:0], 1'b0};
    end
  end

  assign o_serial    = r_shreg[BYTE_W-1];
  assign o_byte_done = (r_bit_cnt == 3'd7);
endmodule

// File: rtl/phy_tx.sv
// 4-lane PHY transmitter: COM preamble after reset, then byte-interleaved lane data.
// Optional macro PHY_TX_COM_REALIGN_EN: all-invalid frames send COM on lane 0.
import phy_pkg::*;

module phy_tx #(
  parameter int                SYNC_FRAMES = 2,
  parameter logic [BYTE_W-1:0] COM_BYTE    = COM_BYTE_DEF,
  parameter logic [BYTE_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic              clk_32f,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_in_0,
  input  logic [BYTE_W-1:0] data_in_1,
  input  logic [BYTE_W-1:0] data_in_2,
  input  logic [BYTE_W-1:0] data_in_3,
  input  logic              valid_in_0,
  input  logic              valid_in_1,
  input  logic              valid_in_2,
  input  logic              valid_in_3,
  output logic              datos_paralelo_serial,
  output logic              ready_out,
  output logic              active_out,
  output logic              idle_out
);
  localparam int SW = (SYNC_FRAMES > 1) ? $clog2(SYNC_FRAMES) : 1;

  tx_state_e r_state, w_state_nxt;
  logic [1:0]                     r_lane_cnt;
  logic [SW-1:0]                  r_sync_cnt;
  logic [LANES-1:1][BYTE_W-1:0]   r_buf_data;
  logic [LANES-1:1]               r_buf_vld;
  logic                           r_idle;

  logic              w_byte_done, w_frame_end, w_sync_last, w_sample, w_all_idle;
  logic [BYTE_W-1:0] w_lane0_byte, w_buf_byte, w_next_byte;
  logic [LANES-1:0]  w_in_vld;

  assign w_in_vld    = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};
  assign w_all_idle  = ~|w_in_vld;
  assign w_frame_end = w_byte_done && (r_lane_cnt == 2'd3);
  assign w_sync_last = (r_sync_cnt == SW'(SYNC_FRAMES - 1));
  assign w_sample    = w_frame_end && ((r_state == ST_ACTIVE) || w_sync_last);

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_SYNC && w_frame_end && w_sync_last) w_state_nxt = ST_ACTIVE;
  end

  always_ff @(posedge clk_32f) begin
    if (rst) begin
      r_state    <= ST_SYNC;
      r_lane_cnt <= '0;
      r_sync_cnt <= '0;
      r_buf_data <= '0;
      r_buf_vld  <= '0;
      r_idle     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_byte_done) r_lane_cnt <= r_lane_cnt + 2'd1;
      if (r_state == ST_SYNC && w_frame_end && !w_sync_last) r_sync_cnt <= r_sync_cnt + SW'(1);
      if (w_sample) begin
        r_buf_data <= {data_in_3, data_in_2, data_in_1};
        r_buf_vld  <= w_in_vld[LANES-1:1];
        r_idle     <= w_all_idle;
      end
    end
  end

  // Lane 0 bypasses the buffer so it can go out on the very next cycle.
`ifdef PHY_TX_COM_REALIGN_EN
  assign w_lane0_byte = lane_byte(valid_in_0, data_in_0, w_all_idle ? COM_BYTE : IDLE_BYTE);
`else
  assign w_lane0_byte = lane_byte(valid_in_0, data_in_0, IDLE_BYTE);
`endif

  always_comb begin
    w_buf_byte = IDLE_BYTE;
    case (r_lane_cnt)
      2'd0:    w_buf_byte = lane_byte(r_buf_vld[1], r_buf_data[1], IDLE_BYTE);
      2'd1:    w_buf_byte = lane_byte(r_buf_vld[2], r_buf_data[2], IDLE_BYTE);
      2'd2:    w_buf_byte = lane_byte(r_buf_vld[3], r_buf_data[3], IDLE_BYTE);
      default: w_buf_byte = IDLE_BYTE;
    endcase
  end

  always_comb begin
    w_next_byte = w_buf_byte;
    if (w_sample)                 w_next_byte = w_lane0_byte;
    else if (r_state == ST_SYNC)  w_next_byte = COM_BYTE;
  end

  phy_tx_serializer #(.RESET_BYTE(COM_BYTE)) u_ser (
    .i_clk       (clk_32f),
    .i_rst       (rst),
    .i_load_byte (w_next_byte),
    .o_serial    (datos_paralelo_serial),
    .o_byte_done (w_byte_done)
  );

  assign ready_out  = w_sample;
  assign active_out = (r_state == ST_ACTIVE);
  assign idle_out   = r_idle;
endmodule

// File: tb/tb_phy_tx.sv
// Directed bench for phy_tx: preamble, table of data frames, mid-frame reset.
module tb_phy_tx;
  logic       clk_32f = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in_0 = '0, data_in_1 = '0, data_in_2 = '0, data_in_3 = '0;
  logic       valid_in_0 = 1'b0, valid_in_1 = 1'b0, valid_in_2 = 1'b0, valid_in_3 = 1'b0;
  logic       datos_paralelo_serial, ready_out, active_out, idle_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] com_v  = 8'hBC;
  logic [7:0] idle_v = 8'h7C;

  phy_tx dut (
    .clk_32f(clk_32f), .rst(rst),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .valid_in_0(valid_in_0), .valid_in_1(valid_in_1), .valid_in_2(valid_in_2), .valid_in_3(valid_in_3),
    .datos_paralelo_serial(datos_paralelo_serial), .ready_out(ready_out),
    .active_out(active_out), .idle_out(idle_out)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [3:0][7:0] d;
    logic [3:0]      v;
    logic [3:0][7:0] e;
    logic            e_idle;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_32f);
    @(negedge clk_32f);
  endtask

  task automatic drive(input logic [3:0][7:0] d, input logic [3:0] v);
    data_in_0 = d[0]; data_in_1 = d[1]; data_in_2 = d[2]; data_in_3 = d[3];
    valid_in_0 = v[0]; valid_in_1 = v[1]; valid_in_2 = v[2]; valid_in_3 = v[3];
  endtask

  task automatic drive_junk();
    logic [3:0][7:0] d;
    d = {$urandom, $urandom, $urandom, $urandom} >> 96;
    d = $urandom;
    drive(d, 4'($urandom));
  endtask

  // Entered at the negedge of cycle 0 (first cycle after reset release);
  // leaves at the negedge of cycle 63, the first sampling cycle.
  task automatic check_preamble();
    for (int c = 0; c < 64; c++) begin
      chk("pre_serial", 32'(datos_paralelo_serial), 32'(com_v[7 - (c % 8)]));
      chk("pre_ready",  32'(ready_out), 32'(c == 63));
      chk("pre_active", 32'(active_out), 32'(0));
      chk("pre_idle",   32'(idle_out), 32'(0));
      if (c < 63) begin
        drive_junk();
        step();
      end
    end
  endtask

  // Entered at the negedge of a sampling cycle; leaves at the next one.
  task automatic run_frame(input vec_t vv, input int idx);
    logic [7:0] got;
    chk($sformatf("v%0d_ready_in", idx), 32'(ready_out), 32'(1));
    drive(vv.d, vv.v);
    for (int k = 0; k < 32; k++) begin
      step();
      got = {got[6:0], datos_paralelo_serial};
      if (k % 8 == 7)
        chk($sformatf("v%0d_lane%0d_byte", idx, k / 8), 32'(got), 32'(vv.e[k / 8]));
      chk($sformatf("v%0d_ready", idx), 32'(ready_out), 32'(k == 31));
      chk($sformatf("v%0d_idle", idx),  32'(idle_out), 32'(vv.e_idle));
      chk($sformatf("v%0d_active", idx), 32'(active_out), 32'(1));
      if (k < 31) drive_junk();
    end
  endtask

  initial begin
    logic [7:0] l0_all_idle;
`ifdef PHY_TX_COM_REALIGN_EN
    l0_all_idle = com_v;
`else
    l0_all_idle = idle_v;
`endif
    vecs[0] = '{d: {8'h00, 8'hFF, 8'h3C, 8'hA5}, v: 4'b1111,
                e: {8'h00, 8'hFF, 8'h3C, 8'hA5}, e_idle: 1'b0};
    vecs[1] = '{d: {8'h33, 8'h22, 8'h55, 8'h11}, v: 4'b1101,
                e: {8'h33, 8'h22, 8'h7C, 8'h11}, e_idle: 1'b0};
    vecs[2] = '{d: {8'h12, 8'h34, 8'h56, 8'h78}, v: 4'b0000,
                e: {8'h7C, 8'h7C, 8'h7C, l0_all_idle}, e_idle: 1'b1};
    vecs[3] = '{d: {8'hF0, 8'h0F, 8'hC3, 8'h5A}, v: 4'b1000,
                e: {8'hF0, 8'h7C, 8'h7C, 8'h7C}, e_idle: 1'b0};
    vecs[4] = '{d: {8'h00, 8'h00, 8'h00, 8'h00}, v: 4'b0000,
                e: {8'h7C, 8'h7C, 8'h7C, l0_all_idle}, e_idle: 1'b1};
    vecs[5] = '{d: {8'h7F, 8'hFE, 8'h80, 8'h01}, v: 4'b1111,
                e: {8'h7F, 8'hFE, 8'h80, 8'h01}, e_idle: 1'b0};

    repeat (3) step();
    chk("rst_serial", 32'(datos_paralelo_serial), 32'(1));
    chk("rst_ready",  32'(ready_out),  32'(0));
    chk("rst_active", 32'(active_out), 32'(0));
    chk("rst_idle",   32'(idle_out),   32'(0));

    rst = 1'b0;
    check_preamble();
    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // Reset in the middle of lane 2; nothing of this frame may survive.
    drive({8'hEF, 8'hBE, 8'hAD, 8'hDE}, 4'b1111);
    for (int k = 0; k < 17; k++) begin
      step();
      if (k < 16) drive_junk();
    end
    rst = 1'b1;
    step();
    chk("mid_rst_serial", 32'(datos_paralelo_serial), 32'(1));
    chk("mid_rst_ready",  32'(ready_out),  32'(0));
    chk("mid_rst_active", 32'(active_out), 32'(0));
    chk("mid_rst_idle",   32'(idle_out),   32'(0));
    rst = 1'b0;
    check_preamble();
    run_frame(vecs[1], 10);
    run_frame(vecs[0], 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
